tm1638_key_reader: RTL and testbench

//  Key-scan reader for the TM1638 LED/key board: the read direction of the display link.
//  On each start pulse it sends READ-KEYS command 0x42, releases DIO, clocks in 4 scan

---
 rtl/tm1638_key_reader.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// -----------------------------------------------------------------------------
// tm1638_key_reader
//
// Purpose:
//   Reads the key matrix of a TM1638 LED/key board. Each accepted start pulse
//   lowers STB and sends the READ-KEYS command (0x42, LSB first). It then
//   releases DIO, waits with tm_clk held high, and clocks in 4 scan bytes.
//   From those bytes it extracts an 8-bit key vector (S1..S8).
//   The tm_clk / tm_stb / DIO lines are shared with the display writer at top
//   level. An external arbiter only issues start while the writer is idle.
//
// Parameters:
//   CLK_DIV      clk_50M cycles per tm_clk half-period (>= 2)
//   WAIT_CYCLES  cycles tm_clk stays high with DIO released after the command
//
// Ports:
//   clk_50M    in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   begin one scan (sampled only while idle)
//   busy       out  high from the cycle after an accepted start to end of GAP
//   done       out  one-cycle pulse; keys valid from this cycle
//   keys       out  pressed keys, bit k = S(k+1); held until the next done
//   key_press  out  keys newly pressed at this done (optional feature)
//   tm_clk     out  TM1638 CLK
//   tm_stb     out  TM1638 STB, active low
//   dio_out    out  DIO drive value
//   dio_oe     out  DIO output enable (tristate built at top level)
//   dio_in     in   DIO pad value
//
// Configuration macro:
//   KEY_EDGE_EN  when defined, key_press pulses (new & ~previous) on done.
//                When undefined, key_press is tied to zero.
//
// All pin-facing outputs are registered. Their next value is decoded from
// the next FSM state and counters, so the pins change exactly on state or
// slot boundaries and never glitch.
// -----------------------------------------------------------------------------
module tm1638_key_reader #(
    parameter int CLK_DIV     = 50,
    parameter int WAIT_CYCLES = 100
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] keys,
    output logic [7:0] key_press,
    output logic       tm_clk,
    output logic       tm_stb,
    output logic       dio_out,
    output logic       dio_oe,
    input  logic       dio_in
);

    localparam int SLOT_CYCLES = 2 * CLK_DIV;
    localparam int CNT_MAX     = (SLOT_CYCLES > WAIT_CYCLES) ? SLOT_CYCLES : WAIT_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX);
    localparam int BIT_W       = $clog2(32);

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(7);
    localparam logic [BIT_W-1:0] READ_LAST = BIT_W'(31);

    localparam logic [7:0] CMD_READ_KEYS = 8'h42;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_READ,
        S_DONE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;     // cycle within slot / WAIT / GAP
    logic [BIT_W-1:0] bit_q, bit_d;     // slot index within CMD or READ
    logic [7:0]       acc_q, acc_d;     // key bits collected during READ

    logic       tm_clk_q, tm_clk_d;
    logic       tm_stb_q, tm_stb_d;
    logic       dio_out_q, dio_out_d;
    logic       dio_oe_q, dio_oe_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] keys_q, keys_d;

    // The sample point is the last cycle of the low phase in a READ slot.
    logic       sample_en;
    logic [3:0] samp_lo;    // slot carries bit0 of byte gi  -> S(gi+1)
    logic [3:0] samp_hi;    // slot carries bit4 of byte gi  -> S(gi+5)

    assign sample_en = (state_q == S_READ) && (cnt_q == HALF_LAST);

    // Only bit0 and bit4 of each scan byte map to keys. The other 24 bits
    // are clocked past without being stored.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot_sel
            assign samp_lo[gi] = sample_en && (bit_q == BIT_W'(gi * 8));
            assign samp_hi[gi] = sample_en && (bit_q == BIT_W'(gi * 8 + 4));
        end
    endgenerate

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (samp_lo[i]) acc_d[i]     = dio_in;
            if (samp_hi[i]) acc_d[i + 4] = dio_in;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_CMD: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == CMD_LAST) begin
                        state_d = S_WAIT;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == READ_LAST) begin
                        state_d = S_DONE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Pin and status decode from the *next* state, registered below.
    always_comb begin
        tm_stb_d  = 1'b1;
        tm_clk_d  = 1'b1;
        dio_out_d = 1'b1;
        dio_oe_d  = 1'b0;
        busy_d    = 1'b0;
        unique case (state_d)
            S_CMD: begin
                tm_stb_d  = 1'b0;
                tm_clk_d  = (cnt_d >= HALF);
                dio_out_d = CMD_READ_KEYS[bit_d[2:0]];
                dio_oe_d  = 1'b1;
                busy_d    = 1'b1;
            end
            S_WAIT: begin
                tm_stb_d = 1'b0;
                busy_d   = 1'b1;
            end
            S_READ: begin
                tm_stb_d = 1'b0;
                tm_clk_d = (cnt_d >= HALF);
                busy_d   = 1'b1;
            end
            S_DONE, S_GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // acc_q is complete well before the slot-end edge that enters DONE,
    // because the last sample happens half a slot earlier.
    assign done_d = (state_d == S_DONE);

    always_comb begin
        keys_d = keys_q;
        if (done_d) keys_d = acc_q;
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            acc_q     <= '0;
            tm_clk_q  <= 1'b1;
            tm_stb_q  <= 1'b1;
            dio_out_q <= 1'b1;
            dio_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            keys_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            acc_q     <= acc_d;
            tm_clk_q  <= tm_clk_d;
            tm_stb_q  <= tm_stb_d;
            dio_out_q <= dio_out_d;
            dio_oe_q  <= dio_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            keys_q    <= keys_d;
        end
    end

`ifdef KEY_EDGE_EN
    // keys_q still holds the previous scan result on the edge that loads the
    // new one, so it serves as the previous-keys register. It resets to 0.
    logic [7:0] key_press_q, key_press_d;

    always_comb begin
        key_press_d = 8'h00;
        if (done_d) key_press_d = acc_q & ~keys_q;
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            key_press_q <= 8'h00;
        end else begin
            key_press_q <= key_press_d;
        end
    end

    assign key_press = key_press_q;
`else
    assign key_press = 8'h00;
`endif

    assign tm_clk  = tm_clk_q;
    assign tm_stb  = tm_stb_q;
    assign dio_out = dio_out_q;
    assign dio_oe  = dio_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign keys    = keys_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// -----------------------------------------------------------------------------
// tb_tm1638_key_reader
//   Directed bench for tm1638_key_reader with default timing parameters.
//   A small TM1638 slave model returns the scan bytes on tm_clk falling edges
//   and captures the command bits on tm_clk rising edges.
// -----------------------------------------------------------------------------
module tb_tm1638_key_reader;

    localparam int D   = 50;
    localparam int W   = 100;
    localparam int LAT = 1 + 80 * D + W;     // 4101 with defaults
    localparam int CMD_CYCLES  = 16 * D;
    localparam int READ_FIRST  = 1 + 16 * D + W;

    logic       clk_50M = 1'b0;
    logic       reset;
    logic       start;
    logic       dio_in;
    logic       busy;
    logic       done;
    logic [7:0] keys;
    logic [7:0] key_press;
    logic       tm_clk;
    logic       tm_stb;
    logic       dio_out;
    logic       dio_oe;

    tm1638_key_reader #(
        .CLK_DIV     (D),
        .WAIT_CYCLES (W)
    ) dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .keys      (keys),
        .key_press (key_press),
        .tm_clk    (tm_clk),
        .tm_stb    (tm_stb),
        .dio_out   (dio_out),
        .dio_oe    (dio_oe),
        .dio_in    (dio_in)
    );

    always #10 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model state
    logic [31:0] rd_data  = 32'h0;
    int          rise_cnt = 0;
    logic [7:0]  cmd_bits = 8'h0;
    int          oe_cnt   = 0;

    always @(posedge tm_clk) begin
        if (rise_cnt < 8 && dio_oe) cmd_bits[rise_cnt] = dio_out;
        rise_cnt = rise_cnt + 1;
    end

    always @(negedge tm_clk) begin
        if (rise_cnt >= 8 && rise_cnt < 40) dio_in = rd_data[rise_cnt - 8];
    end

    always @(negedge clk_50M) begin
        if (dio_oe) oe_cnt = oe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_press(input logic [7:0] new_k, input logic [7:0] prev_k);
`ifdef KEY_EDGE_EN
        return new_k & ~prev_k;
`else
        return 8'h00 & (new_k | prev_k);
`endif
    endfunction

    // One full scan. pulse_at: cycle index at which to pulse start again
    // (0 = none). reset_at: cycle index at which to assert reset (0 = none).
    task automatic do_scan(input logic [31:0] data, input int pulse_at, input int reset_at,
                           input logic [7:0] exp_keys, input logic [7:0] exp_kp);
        int lat;
        int g;
        bit got_done;
        bit oe_late;
        bit stb_low;
        bit was_reset;
        rd_data  = data;
        rise_cnt = 0;
        oe_cnt   = 0;
        cmd_bits = 8'h0;
        dio_in   = 1'b1;
        start    = 1'b1;
        @(posedge clk_50M);
        #1;
        start = 1'b0;
        check_eq("stb_fall", {31'b0, tm_stb}, 32'd0);
        check_eq("busy_rise", {31'b0, busy}, 32'd1);
        lat       = 1;
        got_done  = 1'b0;
        oe_late   = 1'b0;
        was_reset = 1'b0;
        while (!got_done && !was_reset && lat < LAT + 100) begin
            start = (lat == pulse_at);
            reset = (lat == reset_at);
            @(posedge clk_50M);
            #1;
            lat = lat + 1;
            if (reset) begin
                reset = 1'b0;
                start = 1'b0;
                check_eq("reset_pins", {26'b0, tm_stb, tm_clk, dio_out, dio_oe, busy, done},
                         32'b111000);
                check_eq("reset_keys", {24'b0, keys}, 32'h0);
                check_eq("reset_kp", {24'b0, key_press}, 32'h0);
                was_reset = 1'b1;
            end else begin
                if (done) got_done = 1'b1;
                if (lat > 1 + CMD_CYCLES && dio_oe) oe_late = 1'b1;
            end
        end
        start = 1'b0;
        if (was_reset) begin
            $display("scan data=%h aborted by reset at cycle %0d", data, lat);
            return;
        end
        check_eq("done_seen", {31'b0, got_done}, 32'd1);
        check_eq("latency", lat, LAT);
        check_eq("keys", {24'b0, keys}, {24'b0, exp_keys});
        check_eq("key_press", {24'b0, key_press}, {24'b0, exp_kp});
        check_eq("stb_at_done", {31'b0, tm_stb}, 32'd1);
        check_eq("cmd_byte", {24'b0, cmd_bits}, 32'h42);
        check_eq("clk_rises", rise_cnt, 40);
        check_eq("oe_cycles", oe_cnt, CMD_CYCLES);
        check_eq("oe_late", {31'b0, oe_late}, 32'd0);
        g       = 0;
        stb_low = 1'b0;
        while (busy && g < 200) begin
            @(posedge clk_50M);
            #1;
            g = g + 1;
            if (!tm_stb) stb_low = 1'b1;
            if (g == 1) begin
                check_eq("done_pulse", {31'b0, done}, 32'd0);
                check_eq("kp_pulse", {24'b0, key_press}, 32'h0);
            end
        end
        check_eq("gap_len", g, D + 1);
        check_eq("stb_gap", {31'b0, stb_low}, 32'd0);
        check_eq("keys_hold", {24'b0, keys}, {24'b0, exp_keys});
        $display("scan data=%h keys=%h key_press=%h latency=%0d gap=%0d",
                 data, keys, exp_kp, lat, g);
    endtask

    initial begin
        int extra_done;
        bit busy_seen;
        reset  = 1'b1;
        start  = 1'b0;
        dio_in = 1'b1;
        repeat (3) @(posedge clk_50M);
        #1;
        check_eq("rst_pins", {26'b0, tm_stb, tm_clk, dio_out, dio_oe, busy, done}, 32'b111000);
        check_eq("rst_keys", {24'b0, keys}, 32'h0);
        check_eq("rst_kp", {24'b0, key_press}, 32'h0);
        reset = 1'b0;
        @(posedge clk_50M);
        #1;

        // Bytes 01,10,00,11 -> keys A9
        do_scan(32'h1100_1001, 0, 0, 8'hA9, exp_press(8'hA9, 8'h00));

        // Extra start pulse mid-READ must be ignored
        do_scan(32'h0000_0001, 2500, 0, 8'h01, exp_press(8'h01, 8'hA9));
        extra_done = 0;
        busy_seen  = 1'b0;
        repeat (200) begin
            @(posedge clk_50M);
            #1;
            if (done) extra_done = extra_done + 1;
            if (busy) busy_seen = 1'b1;
        end
        check_eq("no_extra_done", extra_done, 0);
        check_eq("no_queued_busy", {31'b0, busy_seen}, 32'd0);
        check_eq("keys_after_pulse", {24'b0, keys}, 32'h01);

        // keys 01 -> 03: newly pressed S2
        do_scan(32'h0000_0101, 0, 0, 8'h03, exp_press(8'h03, 8'h01));

        // Reset during READ slot 10, then a normal scan
        do_scan(32'hFFFF_FFFF, 0, READ_FIRST + 20 * D + 19, 8'h00, 8'h00);
        @(posedge clk_50M);
        #1;
        check_eq("idle_after_rst", {30'b0, busy, tm_stb}, 32'b01);
        do_scan(32'h1010_1010, 0, 0, 8'hF0, exp_press(8'hF0, 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
